// File: rtl/redmule_mx_decoder_if.sv
// Handshake bundle for the MX (E4M3 + E8M0) to FP16 decoder.
// The slave modport is the decoder side; the master modport is its environment.
interface redmule_mx_decoder_if #(
    parameter int DATA_W    = 256,
    parameter int BITW      = 16,
    parameter int NUM_LANES = 8
);
    logic                      mx_val_valid_i;
    logic                      mx_val_ready_o;
    logic [DATA_W-1:0]         mx_val_data_i;
    logic                      mx_exp_valid_i;
    logic                      mx_exp_ready_o;
    logic [7:0]                mx_exp_data_i;
    logic                      fp16_valid_o;
    logic                      fp16_ready_i;
    logic [NUM_LANES*BITW-1:0] fp16_data_o;
    logic                      busy_o;

    modport slave (
        input  mx_val_valid_i, mx_val_data_i, mx_exp_valid_i, mx_exp_data_i, fp16_ready_i,
        output mx_val_ready_o, mx_exp_ready_o, fp16_valid_o, fp16_data_o, busy_o
    );

    modport master (
        output mx_val_valid_i, mx_val_data_i, mx_exp_valid_i, mx_exp_data_i, fp16_ready_i,
        input  mx_val_ready_o, mx_exp_ready_o, fp16_valid_o, fp16_data_o, busy_o
    );
endinterface

// File: rtl/redmule_mx_decoder.sv
// Decodes a block of E4M3 elements with a shared E8M0 exponent into FP16 beats of NUM_LANES lanes.
// Define REDMULE_MX_DEC_BACK_TO_BACK_EN to accept the next block on the last beat (no bubble).
module redmule_mx_decoder #(
    parameter int DATA_W    = 256,
    parameter int BITW      = 16,
    parameter int NUM_LANES = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    redmule_mx_decoder_if.slave  bus
);
    localparam int NUM_ELEMS  = DATA_W / 8;
    localparam int NUM_GROUPS = NUM_ELEMS / NUM_LANES;
    localparam int IDX_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int GRP_W      = NUM_LANES * 8;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  group_idx_q;
    logic [DATA_W-1:0] blk_q;
    logic [7:0]        shexp_q;

    logic                      last_beat;
    logic                      accept_win;
    logic                      xfer;
    logic [GRP_W-1:0]          grp_w [NUM_GROUPS];
    logic [GRP_W-1:0]          sel_grp;
    logic [NUM_LANES*BITW-1:0] lanes_w;

    // Exact E4M3 -> FP16 conversion; the 3-bit mantissa fits the 10-bit field without rounding.
    function automatic logic [15:0] decode(input logic [7:0] el, input logic [7:0] sh);
        logic              s;
        logic [3:0]        e8;
        logic [2:0]        m8;
        logic signed [9:0] e16;
        logic [15:0]       res;
        s   = el[7];
        e8  = el[6:3];
        m8  = el[2:0];
        e16 = $signed({6'b0, e8}) + $signed({2'b0, sh}) - 10'sd119;
        if (sh == 8'hFF)          res = 16'h7E00;
        else if (e8 == 4'd0)      res = {s, 15'b0};
        else if (e8 == 4'd15)     res = (m8 == 3'd0) ? {s, 5'h1F, 10'h000} : {s, 5'h1F, 10'h200};
        else if (e16 <= 10'sd0)   res = {s, 15'b0};
        else if (e16 >= 10'sd31)  res = {s, 5'h1E, 10'h3FF};
        else                      res = {s, e16[4:0], m8, 7'b0};
        return res;
    endfunction

    assign last_beat = (group_idx_q == IDX_W'(NUM_GROUPS - 1));

`ifdef REDMULE_MX_DEC_BACK_TO_BACK_EN
    assign accept_win = (state_q == IDLE) ||
                        ((state_q == EMIT) && last_beat && bus.fp16_ready_i);
`else
    assign accept_win = (state_q == IDLE);
`endif

    // Each channel's ready waits on the other's valid so both always transfer together.
    assign bus.mx_val_ready_o = !rst_i && accept_win && bus.mx_exp_valid_i;
    assign bus.mx_exp_ready_o = !rst_i && accept_win && bus.mx_val_valid_i;
    assign xfer               = bus.mx_val_valid_i && bus.mx_val_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            group_idx_q <= '0;
            blk_q       <= '0;
            shexp_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        blk_q       <= bus.mx_val_data_i;
                        shexp_q     <= bus.mx_exp_data_i;
                        group_idx_q <= '0;
                        state_q     <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.fp16_ready_i) begin
                        if (!last_beat) begin
                            group_idx_q <= group_idx_q + IDX_W'(1);
                        end else if (xfer) begin
                            blk_q       <= bus.mx_val_data_i;
                            shexp_q     <= bus.mx_exp_data_i;
                            group_idx_q <= '0;
                        end else begin
                            group_idx_q <= '0;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_grp
        assign grp_w[gi] = blk_q[gi*GRP_W +: GRP_W];
    end

    if (NUM_GROUPS > 1) begin : g_sel_multi
        assign sel_grp = grp_w[group_idx_q];
    end else begin : g_sel_single
        assign sel_grp = grp_w[0];
    end

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        assign lanes_w[gi*BITW +: BITW] = BITW'(decode(sel_grp[gi*8 +: 8], shexp_q));
    end

    assign bus.fp16_valid_o = (state_q == EMIT);
    assign bus.busy_o       = (state_q == EMIT);
    assign bus.fp16_data_o  = (state_q == EMIT) ? lanes_w : '0;
endmodule

// File: tb/tb_redmule_mx_decoder.sv
// Directed bench for redmule_mx_decoder: decode rules, latency, backpressure, skew, reset, back-to-back.
module tb_redmule_mx_decoder;
    localparam int DATA_W     = 256;
    localparam int BITW       = 16;
    localparam int NUM_LANES  = 8;
    localparam int NUM_GROUPS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    redmule_mx_decoder_if #(.DATA_W(DATA_W), .BITW(BITW), .NUM_LANES(NUM_LANES)) bus ();

    redmule_mx_decoder #(.DATA_W(DATA_W), .BITW(BITW), .NUM_LANES(NUM_LANES)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rep(input logic [15:0] v);
        return {8{v}};
    endfunction

    // Beat g of the ordered block: element i=8g+l is 8+i (e=g+1, m=l); shared 0x78 gives e16=g+2.
    function automatic logic [127:0] ord_beat(input int g);
        logic [127:0] v;
        for (int l = 0; l < NUM_LANES; l++) v[16*l +: 16] = 16'(((g + 2) << 10) | (l << 7));
        return v;
    endfunction

    task automatic load(input string tag, input logic [255:0] d, input logic [7:0] e);
        bus.mx_val_data_i  = d;
        bus.mx_exp_data_i  = e;
        bus.mx_val_valid_i = 1'b1;
        bus.mx_exp_valid_i = 1'b1;
        #1;
        chk({tag, "_val_rdy"}, 128'(bus.mx_val_ready_o), 128'(1));
        chk({tag, "_exp_rdy"}, 128'(bus.mx_exp_ready_o), 128'(1));
        chk({tag, "_pre_valid"}, 128'(bus.fp16_valid_o), 128'(0));
        tick();
        bus.mx_val_valid_i = 1'b0;
        bus.mx_exp_valid_i = 1'b0;
        chk({tag, "_lat_valid"}, 128'(bus.fp16_valid_o), 128'(1));
        chk({tag, "_busy"}, 128'(bus.busy_o), 128'(1));
    endtask

    task automatic drain(input string tag, input logic [127:0] expv);
        bus.fp16_ready_i = 1'b1;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            chk({tag, "_valid"}, 128'(bus.fp16_valid_o), 128'(1));
            chk({tag, "_data"}, bus.fp16_data_o, expv);
            tick();
        end
        chk({tag, "_end_valid"}, 128'(bus.fp16_valid_o), 128'(0));
        chk({tag, "_end_data"}, bus.fp16_data_o, 128'(0));
        chk({tag, "_end_busy"}, 128'(bus.busy_o), 128'(0));
    endtask

    initial begin
        logic [255:0] ord_blk;
        int           beat;
        int           cyc;
        logic         hs;
        bit           b2b;
`ifdef REDMULE_MX_DEC_BACK_TO_BACK_EN
        b2b = 1'b1;
`else
        b2b = 1'b0;
`endif
        for (int i = 0; i < 32; i++) ord_blk[8*i +: 8] = 8'(8 + i);

        bus.mx_val_valid_i = 1'b1;
        bus.mx_exp_valid_i = 1'b1;
        bus.mx_val_data_i  = '0;
        bus.mx_exp_data_i  = '0;
        bus.fp16_ready_i   = 1'b1;

        // Reset state, with valids asserted to prove readies stay low.
        repeat (3) tick();
        chk("rst_val_rdy", 128'(bus.mx_val_ready_o), 128'(0));
        chk("rst_exp_rdy", 128'(bus.mx_exp_ready_o), 128'(0));
        chk("rst_valid", 128'(bus.fp16_valid_o), 128'(0));
        chk("rst_data", bus.fp16_data_o, 128'(0));
        chk("rst_busy", 128'(bus.busy_o), 128'(0));
        bus.mx_val_valid_i = 1'b0;
        bus.mx_exp_valid_i = 1'b0;
        rst = 1'b0;
        tick();
        chk("post_rst_valid", 128'(bus.fp16_valid_o), 128'(0));

        // Scenario 1: normal values.
        load("one", {32{8'h70}}, 8'h78);
        drain("one", rep(16'h3C00));
        load("quarter", {32{8'h38}}, 8'h78);
        drain("quarter", rep(16'h2000));
        load("neg", {32{8'hF4}}, 8'h78);
        drain("neg", rep(16'hBE00));

        // Scenario 2: zero/inf/nan/subnormal lanes, then NaN shared exponent.
        load("special", {8{32'h07797880}}, 8'h78);
        drain("special", {2{64'h0000_7E00_7C00_8000}});
        load("shnan", {8{32'h07797880}}, 8'hFF);
        drain("shnan", rep(16'h7E00));

        // Scenario 3: saturation and underflow.
        load("sat", {32{8'h77}}, 8'hA0);
        drain("sat", rep(16'h7BFF));
        load("uflow", {32{8'h08}}, 8'h60);
        drain("uflow", rep(16'h0000));

        // Scenario 4a: value valid leads exponent valid by 3 cycles.
        bus.mx_val_data_i  = ord_blk;
        bus.mx_exp_data_i  = 8'h78;
        bus.mx_val_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("skew_val_rdy", 128'(bus.mx_val_ready_o), 128'(0));
            chk("skew_exp_rdy", 128'(bus.mx_exp_ready_o), 128'(1));
            chk("skew_valid", 128'(bus.fp16_valid_o), 128'(0));
            tick();
        end
        bus.mx_exp_valid_i = 1'b1;
        #1;
        chk("skew_join_rdy", 128'(bus.mx_val_ready_o), 128'(1));
        tick();
        bus.mx_val_valid_i = 1'b0;
        bus.mx_exp_valid_i = 1'b0;
        chk("skew_lat_valid", 128'(bus.fp16_valid_o), 128'(1));

        // Scenario 4b: random backpressure, beats in element order, stable while stalled.
        beat = 0;
        cyc  = 0;
        while (beat < NUM_GROUPS && cyc < 200) begin
            bus.fp16_ready_i = 1'($urandom_range(0, 1));
            chk("bp_valid", 128'(bus.fp16_valid_o), 128'(1));
            chk("bp_data", bus.fp16_data_o, ord_beat(beat));
            hs = bus.fp16_ready_i;
            tick();
            cyc++;
            if (hs) beat++;
        end
        chk("bp_beats", 128'(beat), 128'(NUM_GROUPS));
        chk("bp_end_valid", 128'(bus.fp16_valid_o), 128'(0));

        // Scenario 5: reset pulse after beat 1.
        load("rstmid", {32{8'h70}}, 8'h78);
        bus.fp16_ready_i = 1'b1;
        tick();
        tick();
        chk("rstmid_beat2_valid", 128'(bus.fp16_valid_o), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_valid", 128'(bus.fp16_valid_o), 128'(0));
        chk("rstmid_busy", 128'(bus.busy_o), 128'(0));
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rstmid_stale", 128'(bus.fp16_valid_o), 128'(0));
        end

        // Scenario 6: two blocks with inputs held valid.
        bus.mx_val_data_i  = {32{8'h70}};
        bus.mx_exp_data_i  = 8'h78;
        bus.mx_val_valid_i = 1'b1;
        bus.mx_exp_valid_i = 1'b1;
        bus.fp16_ready_i   = 1'b1;
        #1;
        chk("b2b_a_rdy", 128'(bus.mx_val_ready_o), 128'(1));
        tick();
        bus.mx_val_data_i = {32{8'h38}};
        for (int g = 0; g < NUM_GROUPS; g++) begin
            #1;
            chk("b2b_a_valid", 128'(bus.fp16_valid_o), 128'(1));
            chk("b2b_a_data", bus.fp16_data_o, rep(16'h3C00));
            chk("b2b_a_inrdy", 128'(bus.mx_val_ready_o),
                128'((g == NUM_GROUPS - 1) && b2b));
            tick();
        end
        if (!b2b) begin
            chk("gap_valid", 128'(bus.fp16_valid_o), 128'(0));
            #1;
            chk("gap_rdy", 128'(bus.mx_val_ready_o), 128'(1));
            tick();
        end
        bus.mx_val_valid_i = 1'b0;
        bus.mx_exp_valid_i = 1'b0;
        drain("b2b_b", rep(16'h2000));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/redmule_mx_decoder.md
REDMULE_MX_DECODER -- requirements
Module: redmule_mx_decoder

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 256: MX value block width, packing 8-bit E4M3 elements.
- BITW, default 16: FP16 element width.
- NUM_LANES, default 8: FP16 elements per output beat.
REQ-002 Derived constants SHALL be NUM_ELEMS=DATA_W/8 and NUM_GROUPS=NUM_ELEMS/NUM_LANES. DATA_W SHALL be a multiple of 8*NUM_LANES, and NUM_GROUPS SHALL be at least 1.
REQ-003 Ports SHALL be:
- clk_i  in  1  clock; the block has one clock.
- rst_i  in  1  synchronous, active-high reset.
- mx_val_valid_i  in  1  MX value block valid.
- mx_val_ready_o  out  1  MX value block ready.
- mx_val_data_i  in  DATA_W  E4M3 elements; element i is at bits [8i+:8].
- mx_exp_valid_i  in  1  shared exponent valid.
- mx_exp_ready_o  out  1  shared exponent ready.
- mx_exp_data_i  in  8  E8M0 shared exponent, bias 127.
- fp16_valid_o  out  1  FP16 beat valid.
- fp16_ready_i  in  1  FP16 beat ready.
- fp16_data_o  out  NUM_LANES*BITW  FP16 lanes; lane l is at bits [BITW*l+:BITW].
- busy_o  out  1  high while a block is held.

Function
REQ-004 FSM states SHALL be IDLE and EMIT.
REQ-005 In IDLE, mx_val_ready_o SHALL equal mx_exp_valid_i, and mx_exp_ready_o SHALL equal mx_val_valid_i. Both channels SHALL therefore transfer in the same cycle, and a lone valid SHALL NOT be consumed.
REQ-006 On a joint transfer, the block SHALL register the value block and the exponent, clear group_idx to 0, and move to EMIT.
REQ-007 Latency SHALL be: fp16_valid_o rises exactly one cycle after the transfer cycle.
REQ-008 In EMIT, fp16_valid_o SHALL be 1, and output lane l SHALL be the decode of stored element group_idx*NUM_LANES+l.
REQ-009 fp16_data_o and the beat index SHALL hold stable while fp16_valid_o=1 and fp16_ready_i=0.
REQ-010 When a beat handshakes and group_idx<NUM_GROUPS-1, group_idx SHALL increment.
REQ-011 When the beat with group_idx=NUM_GROUPS-1 handshakes, the FSM SHALL return to IDLE (see REQ-023). With NUM_GROUPS=1, each block SHALL emit exactly one beat.
REQ-012 Outside EMIT, fp16_valid_o SHALL be 0 and fp16_data_o SHALL be 0.
REQ-013 busy_o SHALL be 1 exactly in EMIT.
REQ-014 Element fields SHALL be s=bit7, e8=bits[6:3], m8=bits[2:0]. The per-element output SHALL be:
- Shared exponent 8'hFF: output 16'h7E00 for every element, overriding all other rules.
- e8=0: output {s,15'b0}; E4M3 subnormals flush to zero.
- e8=15, m8=0: output {s,5'h1F,10'h0} (infinity).
- e8=15, m8 != 0: output {s,5'h1F,10'h200} (quiet NaN).
- Otherwise: e16 = e8 + shared - 119, computed signed with at least 10 bits.
REQ-015 For the signed e16, e16<=0 SHALL output {s,15'b0}.
REQ-016 For the signed e16, e16>=31 SHALL saturate to {s,5'h1E,10'h3FF}.
REQ-017 Otherwise the output SHALL be {s,e16[4:0],m8,7'b0}.
REQ-018 Mantissa expansion SHALL be exact; no rounding SHALL occur anywhere in the block.
REQ-019 Decoding SHALL be combinational from the stored registers. No input port SHALL reach fp16_data_o combinationally.

Reset
REQ-020 While rst_i=1 at a clock edge, the FSM SHALL go to IDLE and group_idx, the stored block and the stored exponent SHALL clear to 0.
REQ-021 Reset values SHALL be fp16_valid_o=0, fp16_data_o=0, busy_o=0, mx_val_ready_o=0 and mx_exp_ready_o=0. Both readies SHALL be 0 while rst_i=1.
REQ-022 Reset asserted mid-block SHALL discard the remaining beats, and no beat SHALL be emitted after reset deasserts until a new joint transfer.

Configuration
REQ-023 Macro REDMULE_MX_DEC_BACK_TO_BACK_EN SHALL control back-to-back block acceptance:
- Defined: during the cycle the last beat handshakes, the input readies SHALL also follow the REQ-005 rules. A joint transfer in that cycle SHALL load the next block and remain in EMIT with group_idx=0, so no bubble occurs between blocks.
- Undefined: the input readies SHALL be 0 in EMIT, giving exactly one idle cycle between consecutive blocks.

Verification
REQ-024 Scenario 1: shared=8'h78 with all elements 8'h70 -> 4 beats, every lane 16'h3C00. With element 8'h38 -> 16'h2000. With element 8'hF4 -> 16'hBE00.
REQ-025 Scenario 2: elements 8'h80, 8'h78, 8'h79 and 8'h07 with shared 8'h78 -> 16'h8000, 16'h7C00, 16'h7E00 and 16'h0000. Repeating with shared=8'hFF -> every lane 16'h7E00.
REQ-026 Scenario 3, saturation and underflow: shared=8'hA0 with element 8'h77 -> 16'h7BFF. Shared=8'h60 with element 8'h08 -> 16'h0000.
REQ-027 Scenario 4, backpressure and skew:
- fp16_ready_i toggling randomly: data stays stable while stalled, and beats arrive in element order 0..31.
- mx_val_valid_i high 3 cycles before mx_exp_valid_i: no transfer until both are valid.
REQ-028 Scenario 5, reset mid-block: rst_i pulsed for 1 cycle after beat 1 -> fp16_valid_o=0 the next cycle, and no stale beats follow.
REQ-029 Scenario 6, two blocks with inputs held valid:
- Macro defined: beat 3 of block A is followed directly by beat 0 of block B.
- Macro undefined: exactly one cycle gap between block A and block B.
